pc_run_controller: RTL and testbench
====================================

// Module: pc_run_controller
// PURPOSE
//  Run-control sequencer for one core's program counter. Drives the enable and
//  synchronous-clear inputs of the core's PC incrementor (9-bit PC, inst mem 0..511).
//  Software start/stop/resume/step commands drive it, and a pipeline stall gates it.
//  Halts automatically at a programmed halt address and keeps cycle and instruction
//  counts for the host software/hardware register interface.
// PARAMETERS
//  PC_WIDTH   9   width of PC and halt_addr (MEM_ADDR_WIDTH-1)
//  CNT_WIDTH  32  width of cycle_count and inst_count (saturating)
// PORTS
//  clk          in   1          system clock, rising edge
//  reset        in   1          asynchronous, active-high; the only clock and reset
//  start        in   1          pulse: clear PC to 0 and run (accepted in IDLE/HALTED)
//  stop         in   1          pulse: halt at current PC (accepted in RUN/STEP)
//  resume       in   1          pulse: run from current PC (accepted in HALTED only)
//  single_step  in   1          pulse: advance exactly one PC (accepted in HALTED only)
//  stall        in   1          pipeline stall; PC must not advance while high
//  halt_addr    in   PC_WIDTH   PC value at which RUN stops; sampled every cycle
//  pc_in        in   PC_WIDTH   current PC from the incrementor
//  pc_en        out  1          enable to the PC incrementor (combinational)
//  pc_clr       out  1          synchronous clear to the PC incrementor (registered)
//  running      out  1          high in RUN or STEP
//  halted       out  1          high in HALTED
//  cycle_count  out  CNT_WIDTH  cycles spent in RUN/STEP since last start
//  inst_count   out  CNT_WIDTH  cycles with pc_en=1 since last start
// BEHAVIOUR
//  States: IDLE(reset), CLEAR, RUN, STEP, HALTED. 3-bit state register, async reset to IDLE.
//  Reset values: pc_en=0, pc_clr=0, running=0, halted=0, both counts=0.
//   Reset asserted mid-operation: immediate return to IDLE and count clear, no clk edge needed.
//  IDLE:   start -> CLEAR. All other commands ignored.
//  CLEAR:  pc_clr=1 for exactly this one cycle; both counts -> 0; next state RUN unconditionally.
//  RUN:    stop -> HALTED. Else, when pc_in==halt_addr and stall=0 -> HALTED.
//          The instruction at halt_addr does not advance the PC. Otherwise stay.
//  STEP:   stop -> HALTED. Else, after the first cycle with stall=0 -> HALTED
//          (pc_en high in that cycle only). Stays in STEP while stall=1.
//  HALTED: start -> CLEAR; else resume -> RUN; else single_step -> STEP.
//  Command priority when pulses coincide: stop > start > resume > single_step.
//   Commands not accepted in the current state are dropped, not queued.
//  pc_en = (state==RUN && !stall && !stop && pc_in!=halt_addr)
//        | (state==STEP && !stall && !stop).
//   It is combinational so that a stall or stop takes effect in the same cycle.
//  pc_clr, running and halted are registered state decodes; they change one cycle
//   after the causing command.
//  cycle_count: +1 each cycle in RUN or STEP, including stalled cycles.
//   inst_count: +1 each cycle pc_en=1.
//   Both saturate at all-ones, with no wrap. Both hold their values in IDLE and HALTED.
//   Both clear only in CLEAR or on reset.
//  resume with pc_in==halt_addr: enters RUN, then returns to HALTED on the next
//   non-stalled cycle with pc_en=0 (no advance). Use single_step to move past halt_addr.
//  PC wrap (511->0) is the incrementor's behaviour; this block does not detect it.
// TESTING
//  T1 reset during RUN (pc_in=5, counts nonzero): outputs reach reset values
//     immediately; state IDLE.
//  T2 start with halt_addr=4, stall=0: pc_clr=1 for 1 cycle; pc_en high while pc 0..3;
//     pc_en=0 at pc=4; halted=1 next cycle; inst_count=4.
//  T3 RUN, stall held 3 cycles at pc=2: pc_en=0 during stall; cycle_count +3;
//     inst_count unchanged.
//  T4 HALTED at pc=4, single_step with stall=1 for 2 cycles: stays in STEP; then exactly
//     one pc_en pulse; pc=5; HALTED; inst_count +1.
//  T5 RUN, stop and start in same cycle: stop wins; pc_en=0 that cycle; HALTED;
//     counts not cleared.
//  T6 force cycle_count near all-ones (CNT_WIDTH=4): stays at 15 after 20 RUN cycles.

Source files
------------

// File: rtl/pc_run_controller.sv
// pc_run_controller: run-control sequencer for a core's PC incrementor.
// Handles start/stop/resume/step commands and stall gating, halts at halt_addr, and keeps cycle/instruction counts.
module pc_run_controller #(
    parameter int PC_WIDTH  = 9,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 resume,
    input  logic                 single_step,
    input  logic                 stall,
    input  logic [PC_WIDTH-1:0]  halt_addr,
    input  logic [PC_WIDTH-1:0]  pc_in,
    output logic                 pc_en,
    output logic                 pc_clr,
    output logic                 running,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] inst_count
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] STEP   = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [2:0] state, state_nxt;
    logic       at_halt, active;

    assign at_halt = pc_in == halt_addr;
    assign active  = state == RUN || state == STEP;
    // Combinational so a stall or stop blocks the advance in the same cycle.
    assign pc_en   = !stall && !stop && ((state == RUN && !at_halt) || state == STEP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? CLEAR : IDLE;
            CLEAR:   state_nxt = RUN;
            RUN:     state_nxt = (stop || (at_halt && !stall)) ? HALTED : RUN;
            STEP:    state_nxt = (stop || !stall) ? HALTED : STEP;
            HALTED:  state_nxt = start ? CLEAR : resume ? RUN : single_step ? STEP : HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc_clr      <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
            inst_count  <= '0;
        end else begin
            state   <= state_nxt;
            pc_clr  <= state_nxt == CLEAR;
            running <= state_nxt == RUN || state_nxt == STEP;
            halted  <= state_nxt == HALTED;
            if (state == CLEAR) begin
                cycle_count <= '0;
                inst_count  <= '0;
            end else if (active) begin
                if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_WIDTH'(1);
                if (pc_en && inst_count != CNT_MAX) inst_count <= inst_count + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pc_run_controller.sv
// tb_pc_run_controller: randomized run/step/stop transactions with a queue scoreboard checked at each halt.
module tb_pc_run_controller;
    logic        clk = 0, reset = 1;
    logic        start = 0, stop = 0, resume = 0, single_step = 0, stall = 0;
    logic [8:0]  halt_addr = 0, pc;
    logic        pc_en, pc_clr, running, halted;
    logic [31:0] cycle_count, inst_count;
    logic        sat_start = 0;
    logic [8:0]  sat_pc;
    logic        sat_en, sat_clr, sat_run, sat_halt;
    logic [3:0]  sat_cyc, sat_inst;

    typedef struct {
        logic [8:0]  pc;
        logic [31:0] inst;
        logic [31:0] cyc;
    } exp_t;
    exp_t        sb[$];
    int          compared = 0, mismatched = 0;
    logic [8:0]  m_pc = 0;
    logic [31:0] m_inst = 0, m_cyc = 0;
    logic        halted_q = 0;

    pc_run_controller dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .resume(resume),
        .single_step(single_step), .stall(stall), .halt_addr(halt_addr), .pc_in(pc),
        .pc_en(pc_en), .pc_clr(pc_clr), .running(running), .halted(halted),
        .cycle_count(cycle_count), .inst_count(inst_count)
    );

    pc_run_controller #(.PC_WIDTH(9), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .reset(reset), .start(sat_start), .stop(1'b0), .resume(1'b0),
        .single_step(1'b0), .stall(1'b0), .halt_addr(9'd300), .pc_in(sat_pc),
        .pc_en(sat_en), .pc_clr(sat_clr), .running(sat_run), .halted(sat_halt),
        .cycle_count(sat_cyc), .inst_count(sat_inst)
    );

    always #5 clk = ~clk;

    // PC incrementor models driven by the controllers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= '0;
        else if (pc_clr) pc <= '0;
        else if (pc_en) pc <= pc + 9'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sat_pc <= '0;
        else if (sat_clr) sat_pc <= '0;
        else if (sat_en) sat_pc <= sat_pc + 9'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (stall) chk("pc_en_under_stall", {31'd0, pc_en}, 32'd0);
        if (halted && !halted_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_halt", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("halt_pc", {23'd0, pc}, {23'd0, e.pc});
                chk("halt_inst_count", inst_count, e.inst);
                chk("halt_cycle_count", cycle_count, e.cyc);
            end
        end
        halted_q = halted;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_halted;
        int i = 0;
        while (!halted && i < 20) begin
            tick();
            i++;
        end
        chk("halt_timeout", {31'd0, halted}, 32'd1);
    endtask

    // Run from start (pc 0) or resume until the PC reaches halt_addr, with k stall cycles inserted.
    task automatic do_run(input bit is_start, input int extra, input int o, input int k);
        logic [8:0] p0;
        int         n, noise;
        p0 = is_start ? 9'd0 : m_pc;
        n = extra;
        if (o > n) o = n;
        halt_addr = p0 + 9'(extra);
        if (is_start) begin
            m_inst = 0;
            m_cyc  = 0;
            start  = 1;
            resume = 1'($urandom_range(0, 1));
        end else begin
            resume = 1;
        end
        single_step = 1'($urandom_range(0, 1));
        m_inst += 32'(n);
        m_cyc  += 32'(n + k + 1);
        m_pc    = halt_addr;
        sb.push_back('{m_pc, m_inst, m_cyc});
        tick();
        start = 0; resume = 0; single_step = 0;
        if (is_start) begin
            chk("pc_clr_pulse", {31'd0, pc_clr}, 32'd1);
            tick();
            chk("pc_clr_drop", {31'd0, pc_clr}, 32'd0);
        end
        for (int t = 0; t < n + k + 1; t++) begin
            stall = t >= o && t < o + k;
            noise = (t == 0 && n > 0) ? int'($urandom_range(0, 3)) : 0;
            resume = noise == 1;
            single_step = noise == 2;
            start = noise == 3;
            tick();
            resume = 0; single_step = 0; start = 0;
        end
        stall = 0;
        wait_halted();
    endtask

    // Single step from HALTED; k stall cycles first, optionally aborted by stop during the stall.
    task automatic do_step(input int k, input int stop_at);
        halt_addr = 9'($urandom);
        if (stop_at < 0) begin
            m_pc  += 9'd1;
            m_inst += 1;
            m_cyc  += 32'(k + 1);
        end else begin
            m_cyc  += 32'(stop_at + 1);
        end
        sb.push_back('{m_pc, m_inst, m_cyc});
        single_step = 1;
        tick();
        single_step = 0;
        if (stop_at < 0) begin
            for (int t = 0; t < k + 1; t++) begin
                stall = t < k;
                tick();
            end
        end else begin
            for (int t = 0; t <= stop_at; t++) begin
                stall = 1;
                stop = t == stop_at;
                tick();
            end
            stop = 0;
        end
        stall = 0;
        wait_halted();
    endtask

    // Run for m cycles then stop (optionally with a coinciding start, which must lose).
    task automatic do_stop(input bit is_start, input int m, input bit both);
        logic [8:0] p0;
        p0 = is_start ? 9'd0 : m_pc;
        halt_addr = p0 + 9'(m) + 9'($urandom_range(1, 30));
        if (is_start) begin
            m_inst = 0;
            m_cyc  = 0;
        end
        m_inst += 32'(m);
        m_cyc  += 32'(m + 1);
        m_pc    = p0 + 9'(m);
        sb.push_back('{m_pc, m_inst, m_cyc});
        if (is_start) start = 1; else resume = 1;
        tick();
        start = 0; resume = 0;
        if (is_start) tick();
        repeat (m) tick();
        stop = 1;
        start = both;
        #1 chk("pc_en_on_stop", {31'd0, pc_en}, 32'd0);
        tick();
        stop = 0; start = 0;
        wait_halted();
    endtask

    initial begin
        int r, k;
        tick();
        tick();
        chk("reset_pc_en", {31'd0, pc_en}, 32'd0);
        chk("reset_pc_clr", {31'd0, pc_clr}, 32'd0);
        chk("reset_running", {31'd0, running}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_cycle_count", cycle_count, 32'd0);
        chk("reset_inst_count", inst_count, 32'd0);
        reset = 0;
        tick();
        resume = 1; single_step = 1; stop = 1;
        tick();
        resume = 0; single_step = 0; stop = 0;
        tick();
        tick();
        chk("idle_ignore_running", {31'd0, running}, 32'd0);
        chk("idle_ignore_halted", {31'd0, halted}, 32'd0);
        chk("idle_ignore_pc_clr", {31'd0, pc_clr}, 32'd0);

        do_run(1, 4, 0, 0);
        do_run(0, 6, 2, 3);
        do_step(2, -1);
        do_stop(0, 3, 1);
        do_run(0, 0, 0, 2);
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 3));
            k = int'($urandom_range(0, 3));
            case (r)
                0: do_run(1, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), k);
                1: do_run(0, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), k);
                2: do_step(k, (k > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, k - 1)) : -1);
                default: do_stop(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
            endcase
        end
        do_run(0, 509, 100, 2);
        do_step(0, -1);

        halt_addr = 9'd200;
        start = 1;
        tick();
        start = 0;
        repeat (8) tick();
        #2 reset = 1;
        #1;
        chk("async_reset_pc_en", {31'd0, pc_en}, 32'd0);
        chk("async_reset_running", {31'd0, running}, 32'd0);
        chk("async_reset_halted", {31'd0, halted}, 32'd0);
        chk("async_reset_pc_clr", {31'd0, pc_clr}, 32'd0);
        chk("async_reset_cycle_count", cycle_count, 32'd0);
        chk("async_reset_inst_count", inst_count, 32'd0);
        tick();
        reset = 0;
        tick();

        sat_start = 1;
        tick();
        sat_start = 0;
        repeat (25) tick();
        chk("sat_cycle_count", {28'd0, sat_cyc}, 32'd15);
        chk("sat_inst_count", {28'd0, sat_inst}, 32'd15);
        chk("sat_running", {31'd0, sat_run}, 32'd1);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
